ch376s_target: RTL
==================

# ch376s_target

SPI target (device-side) port that answers an SPI master such as the CH376S host-interface master, exposing received bytes and a transmit holding register to a Z80-style bus through a two-address (data/status) window. It sits on the device side of the same four-wire link. It oversamples `sck`/`sdcs`/`sdi` in the system clock domain, implements SPI mode 0 MSB-first, and buffers inbound bytes in a small RX FIFO.

## Interface
- `FILL`, 8'hFF — byte shifted out when no TX byte is pending.
- `RX_DEPTH`, 4 — RX FIFO depth in bytes, power of two, 2..16.
- `clk` in 1 — system clock. All logic runs on its rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `rd` in 1 — bus read strobe, one `clk` per access.
- `wr` in 1 — bus write strobe, one `clk` per access.
- `a0` in 1 — register select: 0 selects data, 1 selects status/control.
- `din` in 8 — bus write data.
- `dout` out 8 — bus read data, valid while `rd`=1. It is 8'h00 when `rd`=0.
- `sck` in 1 — SPI clock from the master, asynchronous.
- `sdcs` in 1 — SPI chip select, active low, asynchronous.
- `sdi` in 1 — MOSI, asynchronous.
- `sdo` out 1 — MISO.

## Operation
- **Input synchronisation.** `sck`, `sdcs` and `sdi` each pass through a 2-FF synchroniser. Edges are detected on the synchronised copies.
- **Frame start.** On the falling edge of synchronised `sdcs`:
  - clear the bit counter (3 bits);
  - load the TX shift register from the holding register if it is full, otherwise from `FILL`;
  - mark the holding register empty;
  - drive the shift register MSB on `sdo`.
- **Rising `sck` (while `sdcs`=0).** Shift synchronised `sdi` into the RX shift register (MSB first) and increment the bit counter.
- **Eighth rising edge.**
  - If the FIFO is not full, push the assembled byte into the RX FIFO.
  - If the FIFO is full, drop the byte and set `ovr`.
- **Falling `sck` (while `sdcs`=0).**
  - If the bit counter is 1..7, shift the TX register left and present the new MSB.
  - If the bit counter is 0, a byte boundary has been crossed: reload the TX register from the holding register or `FILL`, as at frame start.
- **`sdcs` rising.**
  - A partial RX byte is discarded and the bit counter is cleared.
  - A TX byte that was only partly shifted is lost; the holding register is untouched.
- **`sdo` while `sdcs`=1.** Driven to 1.
- **Bus data read** (`rd`=1, `a0`=0):
  - `dout` = FIFO head.
  - If the FIFO is not empty, the head is popped at the end of the cycle.
  - Reading an empty FIFO returns the last-popped byte and does not change the pointers.
- **Bus status read** (`rd`=1, `a0`=1):
  - `dout` = {4'b0, `cs_active`, `ovr`, `tx_empty`, `rx_valid`}.
  - `ovr` clears at the end of the cycle.
- **Bus data write** (`wr`=1, `a0`=0): load the holding register and mark it full. This overwrites any unsent byte.
- **Bus control write** (`wr`=1, `a0`=1):
  - `din[0]`=1 flushes the RX FIFO and clears `ovr`.
  - `din[1]`=1 empties the holding register.
- **Simultaneous events.**
  - FIFO push and pop in the same cycle: both occur and the count is unchanged. A push into a full FIFO with a simultaneous pop succeeds and does not set `ovr`.
  - Byte-boundary reload and bus data write in the same cycle: the reload uses the old holding content, and the new write stays pending.
- **Reset.** Clears all of the following, and any SPI frame in progress is ignored until the next `sdcs` falling edge:
  - FIFO pointers and count;
  - holding register, with `tx_empty`=1;
  - `ovr`=0;
  - shift registers, to `FILL`/0;
  - bit counter;
  - synchronisers, to `sck`=0, `sdcs`=1, `sdi`=0;
  - outputs `sdo`=1 and `dout`=8'h00.

## Timing
- The master must meet all of the following:
  - `sck` high ≥ 3 `clk` and low ≥ 3 `clk`;
  - `sdcs` setup before the first `sck` rise ≥ 4 `clk`;
  - `sdcs` hold after the last `sck` fall ≥ 3 `clk`.
- Pin edge to internal action: 3 `clk` (2 sync stages plus edge register).
- `sdo` updates 1 `clk` after the detected `sck` fall or `sdcs` fall, so it changes ≤ 4 `clk` after the pin edge.
- The received byte is visible as `rx_valid`=1 on the status read 1 `clk` after the internal 8th rising edge.
- `dout` is combinational from `rd`/`a0` and registered state. Pops and clears take effect on the `clk` edge that ends the `rd` cycle.

## Configuration
- `CH376S_TARGET_RX_FIFO_EN` defined: RX buffering is a `RX_DEPTH`-entry circular FIFO. `rx_valid` means count ≠ 0, and `ovr` sets when a byte completes with count = `RX_DEPTH`.
- Not defined: RX buffering is a single byte register and `RX_DEPTH` is ignored.
  - `rx_valid` is set on byte complete and cleared on data read.
  - A byte completing while `rx_valid`=1 overwrites the register and sets `ovr`.

## Test plan
- Reset, then status read -> 8'h02 (`tx_empty` only), and `sdo`=1.
- Write 8'hA5 to data, then the master clocks one frame sending 8'h3C -> master samples 8'hA5; status = 8'h03; data read = 8'h3C; next status = 8'h02.
- Master sends 8'h11 and 8'h22 in one frame with no TX write -> master samples 8'hFF, 8'hFF; two data reads return 8'h11 then 8'h22.
- FIFO variant, `RX_DEPTH`=4: master sends 5 bytes 8'h01..8'h05 -> status = 8'h07; reads return 01..04; status after the clearing read = 8'h02.
- `sdcs` raised after 5 bits of 8'hF0 -> no byte pushed and status `rx_valid`=0. The next full frame sending 8'h5A is received as 8'h5A.
- `reset` asserted mid-frame after 4 bits, with the FIFO holding 2 bytes -> status = 8'h02 (plus bit3 if `sdcs` is still low). Remaining `sck` edges of that frame push nothing.

Source files
------------

// File: rtl/ch376s_target.sv
// SPI mode-0 target with a data/status bus window, TX holding register and RX buffer.
// Define CH376S_TARGET_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise a single RX byte register.
module ch376s_target #(
    parameter logic [7:0] FILL     = 8'hFF,
    parameter int         RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd,
    input  logic       wr,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       sck,
    input  logic       sdcs,
    input  logic       sdi,
    output logic       sdo
);

    if (RX_DEPTH < 2 || RX_DEPTH > 16 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
        $error("RX_DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [2:0] {
        LINK_SETTLE1,
        LINK_SETTLE2,
        LINK_WAIT_IDLE,
        LINK_IDLE,
        LINK_FRAME
    } link_t;

    link_t      state, state_next;
    logic [1:0] sck_sync, sdcs_sync, sdi_sync;
    logic       sck_q, sdcs_q;
    logic       sck_rise, sck_fall, sdcs_fall;
    logic       frame_start, frame_end, bit_rise, bit_fall, byte_done;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr, rx_byte, tx_sr, tx_load;
    logic       tx_reload;
    logic [7:0] hold;
    logic       hold_full;
    logic       ovr, ovr_set, rx_valid, pop;
    logic [7:0] rx_head;
    logic       data_rd, stat_rd, data_wr, ctrl_wr, flush, tx_clr;

    // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= 2'b00;
            sdcs_sync <= 2'b11;
            sdi_sync  <= 2'b00;
            sck_q     <= 1'b0;
            sdcs_q    <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            sdcs_sync <= {sdcs_sync[0], sdcs};
            sdi_sync  <= {sdi_sync[0], sdi};
            sck_q     <= sck_sync[1];
            sdcs_q    <= sdcs_sync[1];
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_q;
    assign sck_fall  = ~sck_sync[1] & sck_q;
    assign sdcs_fall = ~sdcs_sync[1] & sdcs_q;

    always_ff @(posedge clk) begin
        if (reset) state <= LINK_SETTLE1;
        else       state <= state_next;
    end

    // After reset the synchroniser holds stale values for two cycles, and a frame already in
    // progress must not be joined, so chip select has to be seen high before a frame can start.
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            LINK_SETTLE1:   state_next = LINK_SETTLE2;
            LINK_SETTLE2:   state_next = LINK_WAIT_IDLE;
            LINK_WAIT_IDLE: if (sdcs_sync[1]) state_next = LINK_IDLE;
            LINK_IDLE: begin
                if (sdcs_fall) begin
                    state_next  = LINK_FRAME;
                    frame_start = 1'b1;
                end
            end
            LINK_FRAME: begin
                if (sdcs_sync[1]) begin
                    state_next = LINK_IDLE;
                    frame_end  = 1'b1;
                end
            end
            default:        state_next = LINK_WAIT_IDLE;
        endcase
    end

    assign bit_rise  = (state == LINK_FRAME) && !sdcs_sync[1] && sck_rise;
    assign bit_fall  = (state == LINK_FRAME) && !sdcs_sync[1] && sck_fall;
    assign byte_done = bit_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr[6:0], sdi_sync[1]};
    assign tx_reload = frame_start || (bit_fall && bit_cnt == 3'd0);
    assign tx_load   = hold_full ? hold : FILL;

    assign data_rd = rd & ~a0;
    assign stat_rd = rd & a0;
    assign data_wr = wr & ~a0;
    assign ctrl_wr = wr & a0;
    assign flush   = ctrl_wr & din[0];
    assign tx_clr  = ctrl_wr & din[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            rx_sr   <= 8'h00;
            tx_sr   <= FILL;
            sdo     <= 1'b1;
        end else begin
            if (frame_start || frame_end) begin
                bit_cnt <= 3'd0;
                rx_sr   <= 8'h00;
            end else if (bit_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= rx_byte;
            end
            if (tx_reload) begin
                tx_sr <= tx_load;
                sdo   <= tx_load[7];
            end else if (bit_fall) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
                sdo   <= tx_sr[6];
            end else if (state != LINK_FRAME || frame_end) begin
                sdo <= 1'b1;
            end
        end
    end

    // A bus write in the same cycle as a reload wins: the reload took the old byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold      <= 8'h00;
            hold_full <= 1'b0;
        end else begin
            if (tx_reload || tx_clr) hold_full <= 1'b0;
            if (data_wr) begin
                hold      <= din;
                hold_full <= 1'b1;
            end
        end
    end

`ifdef CH376S_TARGET_RX_FIFO_EN
    localparam int PW = $clog2(RX_DEPTH);

    logic [7:0]  mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [7:0]  last;
    logic        fifo_full, push;

    assign fifo_full = (count == (PW + 1)'(RX_DEPTH));
    assign rx_valid  = (count != '0);
    assign pop       = data_rd && rx_valid;
    assign push      = byte_done && (!fifo_full || pop);
    assign ovr_set   = byte_done && fifo_full && !pop;
    assign rx_head   = rx_valid ? mem[rd_ptr] : last;

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= 8'h00;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] rx_reg;
    logic       rx_full;

    assign rx_valid = rx_full;
    assign pop      = data_rd && rx_full;
    assign ovr_set  = byte_done && rx_full && !pop;
    assign rx_head  = rx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_reg  <= 8'h00;
            rx_full <= 1'b0;
        end else begin
            if (byte_done) rx_reg <= rx_byte;
            if (flush)          rx_full <= 1'b0;
            else if (byte_done) rx_full <= 1'b1;
            else if (pop)       rx_full <= 1'b0;
        end
    end
`endif

    // A new overrun outranks the clear-on-read so the event is never lost.
    always_ff @(posedge clk) begin
        if (reset)        ovr <= 1'b0;
        else if (flush)   ovr <= 1'b0;
        else if (ovr_set) ovr <= 1'b1;
        else if (stat_rd) ovr <= 1'b0;
    end

    always_comb begin
        dout = 8'h00;
        if (rd) begin
            if (a0) dout = {4'b0000, ~sdcs_sync[1], ovr, ~hold_full, rx_valid};
            else    dout = rx_head;
        end
    end

endmodule
